// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM16K port between requesters A and B, with bounded lock bursts.
// Define RAM_ARB_FIXED_PRIO_EN to make unlocked ties always go to A.
module ram_arbiter #(
    parameter int unsigned AW        = 14,
    parameter int unsigned DW        = 16,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic          b_req,
    input  logic          a_lock,
    input  logic          b_lock,
    input  logic          a_we,
    input  logic          b_we,
    input  logic [AW-1:0] a_addr,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic [DW-1:0] b_wdata,
    output logic          a_gnt,
    output logic          b_gnt,
    output logic          a_rvalid,
    output logic          b_rvalid,
    output logic [DW-1:0] a_rdata,
    output logic [DW-1:0] b_rdata,
    output logic [AW-1:0] ram_address,
    output logic          ram_load,
    output logic [DW-1:0] ram_in,
    input  logic [DW-1:0] ram_out
);

    localparam int unsigned CW = 4;
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_A    = 2'd1;
    localparam logic [1:0] OWN_B    = 2'd2;
    localparam logic [CW-1:0] CNT_SAT   = CW'(15);
    localparam logic [CW-1:0] BURST_CAP = CW'(MAX_BURST);

`ifdef RAM_ARB_FIXED_PRIO_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif

    logic [1:0]    owner_q, owner_d;
    logic          last_b_q, last_b_d;
    logic [CW-1:0] burst_q, burst_d;
    logic          a_rvalid_q, a_rvalid_d;
    logic          b_rvalid_q, b_rvalid_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;
    logic          gnt_a, gnt_b;
    logic [CW-1:0] burst_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q    <= OWN_NONE;
            last_b_q   <= 1'b1;
            burst_q    <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            owner_q    <= owner_d;
            last_b_q   <= last_b_d;
            burst_q    <= burst_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    // Grant decision: lock hold, forced release at the burst cap, then tie-break.
    always_comb begin
        gnt_a      = 1'b0;
        gnt_b      = 1'b0;
        owner_d    = OWN_NONE;
        last_b_d   = last_b_q;
        burst_d    = '0;
        burst_inc  = (burst_q == CNT_SAT) ? CNT_SAT : burst_q + CW'(1);

        if (owner_q == OWN_A && a_req && a_lock) begin
            if (burst_q < BURST_CAP || !b_req) gnt_a = 1'b1;
            else                               gnt_b = 1'b1;
        end else if (owner_q == OWN_B && b_req && b_lock) begin
            if (burst_q < BURST_CAP || !a_req) gnt_b = 1'b1;
            else                               gnt_a = 1'b1;
        end else if (a_req && b_req) begin
            if (FIXED_PRIO || last_b_q) gnt_a = 1'b1;
            else                        gnt_b = 1'b1;
        end else begin
            gnt_a = a_req;
            gnt_b = b_req;
        end

        if (gnt_a) begin
            last_b_d = 1'b0;
            owner_d  = a_lock ? OWN_A : OWN_NONE;
            burst_d  = (owner_q == OWN_A) ? burst_inc : CW'(1);
        end else if (gnt_b) begin
            last_b_d = 1'b1;
            owner_d  = b_lock ? OWN_B : OWN_NONE;
            burst_d  = (owner_q == OWN_B) ? burst_inc : CW'(1);
        end

        a_rvalid_d = gnt_a && !a_we;
        b_rvalid_d = gnt_b && !b_we;
        a_rdata_d  = a_rvalid_d ? ram_out : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? ram_out : b_rdata_q;
    end

    assign a_gnt       = gnt_a;
    assign b_gnt       = gnt_b;
    assign ram_address = gnt_b ? b_addr : a_addr;
    assign ram_in      = gnt_b ? b_wdata : a_wdata;
    assign ram_load    = (gnt_a && a_we) || (gnt_b && b_we);
    assign a_rvalid    = a_rvalid_q;
    assign b_rvalid    = b_rvalid_q;
    assign a_rdata     = a_rdata_q;
    assign b_rdata     = b_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural RAM16K model.
module tb_ram_arbiter;

    localparam int unsigned AW = 14;
    localparam int unsigned DW = 16;

`ifdef RAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          a_req, b_req, a_lock, b_lock, a_we, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [AW-1:0] ram_address;
    logic          ram_load;
    logic [DW-1:0] ram_in, ram_out;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_vec = 0;
    int n_err = 0;

    bit            exp_arv, exp_brv;
    logic [DW-1:0] exp_ard, exp_brd;

    ram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .b_req(b_req), .a_lock(a_lock), .b_lock(b_lock),
        .a_we(a_we), .b_we(b_we), .a_addr(a_addr), .b_addr(b_addr),
        .a_wdata(a_wdata), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .ram_address(ram_address), .ram_load(ram_load), .ram_in(ram_in),
        .ram_out(ram_out)
    );

    always #5 clk = ~clk;

    assign ram_out = mem[ram_address];
    always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One bus cycle: drive, check at the falling edge, update the read-return model.
    task automatic step(input bit ar, input bit al, input bit aw,
                        input bit br, input bit bl, input bit bw,
                        input bit ea, input bit eb);
        a_req = ar; a_lock = al; a_we = aw;
        b_req = br; b_lock = bl; b_we = bw;
        @(negedge clk);
        check("a_gnt", 32'(a_gnt), 32'(ea));
        check("b_gnt", 32'(b_gnt), 32'(eb));
        check("ram_load", 32'(ram_load), 32'((ea && aw) || (eb && bw)));
        check("ram_address", 32'(ram_address), 32'(eb ? b_addr : a_addr));
        check("a_rvalid", 32'(a_rvalid), 32'(exp_arv));
        check("b_rvalid", 32'(b_rvalid), 32'(exp_brv));
        check("a_rdata", 32'(a_rdata), 32'(exp_ard));
        check("b_rdata", 32'(b_rdata), 32'(exp_brd));
        if (reset) begin
            exp_arv = 1'b0; exp_brv = 1'b0;
            exp_ard = '0;   exp_brd = '0;
        end else begin
            exp_arv = ea && !aw;
            exp_brv = eb && !bw;
            if (exp_arv) exp_ard = mem[a_addr];
            if (exp_brv) exp_brd = mem[b_addr];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[10] = 16'hAAAA;
        mem[20] = 16'hBBBB;
        reset = 1'b1;
        a_req = 0; b_req = 0; a_lock = 0; b_lock = 0; a_we = 0; b_we = 0;
        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
        exp_arv = 0; exp_brv = 0; exp_ard = '0; exp_brd = '0;
        @(posedge clk);
        #1;
        idle();
        reset = 1'b0;

        // Write then read back through A.
        a_addr = AW'(5); a_wdata = 16'h1234;
        step(1, 0, 1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        idle();
        check("a_rdata_1234", 32'(a_rdata), 32'h1234);
        idle();

        // Unlocked contention alternates from reset.
        reset = 1'b1;
        idle();
        reset = 1'b0;
        a_addr = AW'(10); b_addr = AW'(20);
        for (int i = 0; i < 6; i++)
            step(1, 0, 0, 1, 0, 0, FIXED || (i % 2 == 0), !FIXED && (i % 2 == 1));
        idle();

        // A lock burst capped at 4 while B waits.
        for (int i = 0; i < 8; i++) begin
            if (FIXED) step(1, i < 5, 0, 1, 0, 0, i != 4, i == 4);
            else       step(1, i < 5, 0, 1, 0, 0, i < 4 || i == 5 || i == 7, i == 4 || i == 6);
        end
        idle();

        // Long A lock with B idle; counter must not wrap below the cap.
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 0, 1, 0);
        step(1, 1, 0, 1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        idle();

        // Reset during a locked A read burst.
        step(1, 1, 0, 0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 1, 0);
        reset = 1'b1;
        step(1, 1, 0, 0, 0, 0, 1, 0);
        reset = 1'b0;
        step(1, 0, 0, 1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0, 0, FIXED, !FIXED);
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
